// File: rtl/z80_multidma.sv
// z80_multidma: multi-channel Z80 memory-to-memory DMA controller.
// Round-robin channel service over BUSRQ/BUSACK bus tenures.

package z80_bus_pkg;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dmaster;
    logic        mreqn;
    logic        iorqn;
    logic        rdn;
    logic        wrn;
  } Z80MasterBus;

  typedef struct packed {
    logic [7:0] dslave;
    logic       mwait;
  } Z80SlaveBus;
endpackage

module z80_multidma
  import z80_bus_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int LEN_W    = 16,
  parameter int BURST    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic                ena,
  input  Z80MasterBus         s_ibus,
  output Z80SlaveBus          s_obus,
  output Z80MasterBus         m_obus,
  input  Z80SlaveBus          m_ibus,
  output logic                busrq,
  input  logic                busack,
  input  logic                rdy,
  output logic [CHANNELS-1:0] done
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef logic [CW-1:0] ch_t;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RD, S_WR, S_NEXT, S_REL
  } state_t;

  state_t state, state_n;
  logic   phase, phase_n;

  ch_t cur, last, pick, rsel, rs;
  logic pick_ok, sel_ok, wr_stb, rd_en;
  logic tenure, latch, adv, fin;
  logic len_one, burst_hit;
  logic wrn_q;
  logic [7:0]  data_q, dsl_q, rdata;
  logic [15:0] bcnt, lfull;
  int          j;

  logic [15:0]      src [CHANNELS];
  logic [15:0]      dst [CHANNELS];
  logic [LEN_W-1:0] len [CHANNELS];
  logic [CHANNELS-1:0] sfix, dfix, busy, pend, done_r;

  logic unused_ok;

  assign rsel = (CHANNELS > 1) ? ch_t'(s_ibus.addr[CW+2:3]) : '0;

  generate
    if ((2 ** CW) == CHANNELS) begin : g_full
      assign sel_ok = 1'b1;
    end else begin : g_part
      assign sel_ok = ({1'b0, rsel} < (CW+1)'(CHANNELS));
    end
  endgenerate

  assign rs     = sel_ok ? rsel : '0;
  assign wr_stb = ena & sel_ok & ~s_ibus.mreqn
                & ~s_ibus.wrn & wrn_q;
  assign rd_en  = ena & sel_ok & ~s_ibus.rdn;

  assign unused_ok = ^{s_ibus.addr[15:CW+3], s_ibus.iorqn};

  assign len_one   = (len[cur] == LEN_W'(1));
  assign burst_hit = (BURST != 0)
                   && (bcnt == 16'(BURST - 1));

  assign busrq  = (state != S_IDLE);
  assign done   = done_r;
  assign s_obus = '{dslave: dsl_q, mwait: 1'b1};

  // Round-robin pick: first pending channel after the last served one
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    j       = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      j = int'(last) + i;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (!pick_ok && pend[ch_t'(j)]) begin
        pick    = ch_t'(j);
        pick_ok = 1'b1;
      end
    end
  end

  // Next-state logic; bus phases step on cen
  always_comb begin
    state_n = state;
    phase_n = phase;
    tenure  = 1'b0;
    latch   = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rdy && pick_ok) begin
          state_n = S_REQ;
          tenure  = 1'b1;
        end
      end
      S_REQ: begin
        if (cen && busack) begin
          state_n = S_RD;
          phase_n = 1'b0;
        end
      end
      S_RD: begin
        if (!busack) begin
          state_n = S_REQ;
          phase_n = 1'b0;
        end else if (cen) begin
          if (!phase) begin
            phase_n = 1'b1;
          end else if (m_ibus.mwait) begin
            latch   = 1'b1;
            phase_n = 1'b0;
            state_n = S_WR;
          end
        end
      end
      S_WR: begin
        if (!busack) begin
          state_n = S_REQ;
          phase_n = 1'b0;
        end else if (cen) begin
          if (!phase) begin
            phase_n = 1'b1;
          end else if (m_ibus.mwait) begin
            phase_n = 1'b0;
            state_n = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (cen) begin
          adv = 1'b1;
          if (len_one) begin
            fin     = 1'b1;
            state_n = S_REL;
          end else if (burst_hit || !rdy) begin
            state_n = S_REL;
          end else begin
            state_n = S_RD;
          end
        end
      end
      S_REL: begin
        if (cen) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      phase <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  end

  // Master bus drive: strobes only in RD/WR
  always_comb begin
    m_obus = '{addr: 16'h0, dmaster: 8'h0,
               mreqn: 1'b1, iorqn: 1'b1,
               rdn: 1'b1, wrn: 1'b1};
    if (state == S_RD) begin
      m_obus.addr  = src[cur];
      m_obus.mreqn = 1'b0;
      m_obus.rdn   = 1'b0;
    end else if (state == S_WR) begin
      m_obus.addr    = dst[cur];
      m_obus.dmaster = data_q;
      m_obus.mreqn   = 1'b0;
      m_obus.wrn     = ~phase;
    end
  end

  // Register window readback mux
  always_comb begin
    lfull = 16'(len[rs]);
    rdata = 8'h0;
    case (s_ibus.addr[2:0])
      3'd0: rdata = src[rs][7:0];
      3'd1: rdata = src[rs][15:8];
      3'd2: rdata = dst[rs][7:0];
      3'd3: rdata = dst[rs][15:8];
      3'd4: rdata = lfull[7:0];
      3'd5: rdata = lfull[15:8];
      3'd6: rdata = {5'b0, dfix[rs], sfix[rs], 1'b0};
      default: rdata = {6'b0, done_r[rs], busy[rs]};
    endcase
  end

  // Channel registers, transfer datapath and slave port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= '0;
      last   <= ch_t'(CHANNELS - 1);
      bcnt   <= '0;
      data_q <= '0;
      dsl_q  <= '0;
      wrn_q  <= 1'b1;
      sfix   <= '0;
      dfix   <= '0;
      busy   <= '0;
      pend   <= '0;
      done_r <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        src[c] <= '0;
        dst[c] <= '0;
        len[c] <= '0;
      end
    end else begin
      wrn_q <= s_ibus.wrn;
      if (rd_en) dsl_q <= rdata;
      if (tenure) begin
        cur  <= pick;
        last <= pick;
        bcnt <= '0;
      end
      if (latch) data_q <= m_ibus.dslave;
      if (adv) begin
        len[cur] <= len[cur] - LEN_W'(1);
        bcnt     <= bcnt + 16'd1;
        if (!sfix[cur]) src[cur] <= src[cur] + 16'd1;
        if (!dfix[cur]) dst[cur] <= dst[cur] + 16'd1;
        if (fin) begin
          busy[cur]   <= 1'b0;
          pend[cur]   <= 1'b0;
          done_r[cur] <= 1'b1;
        end
      end
      if (wr_stb && !busy[rs]) begin
        case (s_ibus.addr[2:0])
          3'd0: src[rs][7:0]  <= s_ibus.dmaster;
          3'd1: src[rs][15:8] <= s_ibus.dmaster;
          3'd2: dst[rs][7:0]  <= s_ibus.dmaster;
          3'd3: dst[rs][15:8] <= s_ibus.dmaster;
          3'd4: len[rs] <= LEN_W'({lfull[15:8], s_ibus.dmaster});
          3'd5: len[rs] <= LEN_W'({s_ibus.dmaster, lfull[7:0]});
          3'd6: begin
            sfix[rs] <= s_ibus.dmaster[1];
            dfix[rs] <= s_ibus.dmaster[2];
            if (s_ibus.dmaster[0]) begin
              if (len[rs] != '0) begin
                busy[rs]   <= 1'b1;
                pend[rs]   <= 1'b1;
                done_r[rs] <= 1'b0;
              end else begin
                done_r[rs] <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_z80_multidma.sv
// tb_z80_multidma: directed bench for z80_multidma.
// Busack follows busrq two cen later; memory data is a fixed hash.

module tb_z80_multidma;
  import z80_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;
  logic ena = 1'b0;
  logic rdy = 1'b1;
  logic mw = 1'b1;
  logic busack;
  logic busrq;
  logic [1:0] done;
  logic [1:0] cc = 2'd0;
  logic [1:0] sh = 2'b00;
  Z80MasterBus s_ibus, m_obus;
  Z80SlaveBus  s_obus, m_ibus;

  int checks = 0;
  int errors = 0;

  logic [15:0] waddr [$];
  logic [7:0]  wdata [$];
  int   rises = 0;
  int   per_ten = 0;
  int   max_per = 0;
  logic rq_seen = 1'b0;
  logic wrn_prev = 1'b1;
  logic rq_prev = 1'b0;

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  function automatic logic [15:0] ra(input int ch, input int off);
    return 16'(ch * 8 + off);
  endfunction

  z80_multidma #(.CHANNELS(2), .LEN_W(16), .BURST(1)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .ena(ena),
    .s_ibus(s_ibus), .s_obus(s_obus),
    .m_obus(m_obus), .m_ibus(m_ibus),
    .busrq(busrq), .busack(busack), .rdy(rdy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cc  <= cc + 2'd1;
    cen <= (cc == 2'd3);
    if (cen) sh <= {sh[0], busrq};
  end

  assign busack = sh[1];
  assign m_ibus = '{dslave: mem(m_obus.addr), mwait: mw};

  always @(negedge clk) begin
    if (!rq_prev && busrq) begin
      rises++;
      per_ten = 0;
    end
    if (wrn_prev && !m_obus.wrn) begin
      waddr.push_back(m_obus.addr);
      wdata.push_back(m_obus.dmaster);
      per_ten++;
      if (per_ten > max_per) max_per = per_ten;
    end
    if (busrq) rq_seen = 1'b1;
    wrn_prev = m_obus.wrn;
    rq_prev  = busrq;
  end

  task automatic clear_mon();
    waddr.delete();
    wdata.delete();
    rises = 0;
    per_ten = 0;
    max_per = 0;
    rq_seen = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic reg_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    s_ibus.addr = a;
    s_ibus.dmaster = d;
    s_ibus.mreqn = 1'b0;
    s_ibus.wrn = 1'b0;
    ena = 1'b1;
    @(negedge clk);
    s_ibus.wrn = 1'b1;
    s_ibus.mreqn = 1'b1;
    ena = 1'b0;
  endtask

  task automatic reg_rd(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    s_ibus.addr = a;
    s_ibus.mreqn = 1'b0;
    s_ibus.rdn = 1'b0;
    ena = 1'b1;
    @(negedge clk);
    d = s_obus.dslave;
    s_ibus.rdn = 1'b1;
    s_ibus.mreqn = 1'b1;
    ena = 1'b0;
  endtask

  task automatic setup(input int ch, input logic [15:0] s,
                       input logic [15:0] d, input logic [15:0] n);
    reg_wr(ra(ch, 0), s[7:0]);
    reg_wr(ra(ch, 1), s[15:8]);
    reg_wr(ra(ch, 2), d[7:0]);
    reg_wr(ra(ch, 3), d[15:8]);
    reg_wr(ra(ch, 4), n[7:0]);
    reg_wr(ra(ch, 5), n[15:8]);
  endtask

  task automatic wait_done(input logic [1:0] m, input string nm);
    int n = 0;
    while ((done & m) != m && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((done & m) != m) begin
      errors++;
      $display("FAIL %s timeout done=%b want %b", nm, done, m);
    end
    repeat (24) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busrq !== 1'b0 || done !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctl busrq=%b done=%b want 0 00", busrq, done);
    end
    checks++;
    if (m_obus !== {16'h0, 8'h0, 4'b1111}) begin
      errors++;
      $display("FAIL reset_mbus got %h want %h", m_obus,
               {16'h0, 8'h0, 4'b1111});
    end
    checks++;
    if (s_obus !== {8'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_sbus got %h want %h", s_obus, {8'h0, 1'b1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_block();
    logic [7:0] r;
    clear_mon();
    setup(0, 16'h1000, 16'h6000, 16'd4);
    reg_wr(ra(0, 6), 8'h01);
    checks++;
    if (busrq !== 1'b0) begin
      errors++;
      $display("FAIL blk_rq_early got %b want 0", busrq);
    end
    @(negedge clk);
    checks++;
    if (busrq !== 1'b1) begin
      errors++;
      $display("FAIL blk_rq_rise got %b want 1", busrq);
    end
    wait_done(2'b01, "blk_done");
    checks++;
    if (busrq !== 1'b0 || waddr.size() != 4) begin
      errors++;
      $display("FAIL blk_end busrq=%b writes=%0d want 0 4",
               busrq, waddr.size());
    end
    for (int i = 0; i < 4 && i < waddr.size(); i++) begin
      checks++;
      if (waddr[i] !== 16'h6000 + 16'(i)
          || wdata[i] !== mem(16'h1000 + 16'(i))) begin
        errors++;
        $display("FAIL blk_byte%0d got %h:%h want %h:%h", i,
                 waddr[i], wdata[i], 16'h6000 + 16'(i),
                 mem(16'h1000 + 16'(i)));
      end
    end
    reg_rd(ra(0, 0), r);
    checks++;
    if (r !== 8'h04) begin
      errors++;
      $display("FAIL blk_src_lo got %h want 04", r);
    end
    reg_rd(ra(0, 1), r);
    checks++;
    if (r !== 8'h10) begin
      errors++;
      $display("FAIL blk_src_hi got %h want 10", r);
    end
    reg_rd(ra(0, 2), r);
    checks++;
    if (r !== 8'h04) begin
      errors++;
      $display("FAIL blk_dst_lo got %h want 04", r);
    end
    reg_rd(ra(0, 3), r);
    checks++;
    if (r !== 8'h60) begin
      errors++;
      $display("FAIL blk_dst_hi got %h want 60", r);
    end
    reg_rd(ra(0, 7), r);
    checks++;
    if (r !== 8'h02) begin
      errors++;
      $display("FAIL blk_status got %h want 02", r);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] ea [6];
    logic [15:0] es [6];
    ea = '{16'h2000, 16'h3000, 16'h2001, 16'h3001, 16'h2002, 16'h3002};
    es = '{16'h1100, 16'h1200, 16'h1101, 16'h1201, 16'h1102, 16'h1202};
    do_reset();
    rdy = 1'b0;
    setup(0, 16'h1100, 16'h2000, 16'd3);
    setup(1, 16'h1200, 16'h3000, 16'd3);
    reg_wr(ra(0, 6), 8'h01);
    reg_wr(ra(1, 6), 8'h01);
    clear_mon();
    rdy = 1'b1;
    wait_done(2'b11, "rr_done");
    checks++;
    if (rises != 6 || max_per != 1 || waddr.size() != 6) begin
      errors++;
      $display("FAIL rr_tenures rises=%0d max=%0d writes=%0d want 6 1 6",
               rises, max_per, waddr.size());
    end
    for (int i = 0; i < 6 && i < waddr.size(); i++) begin
      checks++;
      if (waddr[i] !== ea[i] || wdata[i] !== mem(es[i])) begin
        errors++;
        $display("FAIL rr_byte%0d got %h:%h want %h:%h", i,
                 waddr[i], wdata[i], ea[i], mem(es[i]));
      end
    end
  endtask

  task automatic test_wrap_fix();
    logic [7:0] r;
    logic [15:0] es [3];
    es = '{16'hFFFE, 16'hFFFF, 16'h0000};
    do_reset();
    clear_mon();
    setup(0, 16'hFFFE, 16'h7C00, 16'd3);
    reg_wr(ra(0, 6), 8'h05);
    wait_done(2'b01, "wrap_done");
    checks++;
    if (waddr.size() != 3) begin
      errors++;
      $display("FAIL wrap_count got %0d want 3", waddr.size());
    end
    for (int i = 0; i < 3 && i < waddr.size(); i++) begin
      checks++;
      if (waddr[i] !== 16'h7C00 || wdata[i] !== mem(es[i])) begin
        errors++;
        $display("FAIL wrap_byte%0d got %h:%h want 7c00:%h", i,
                 waddr[i], wdata[i], mem(es[i]));
      end
    end
    reg_rd(ra(0, 0), r);
    checks++;
    if (r !== 8'h01) begin
      errors++;
      $display("FAIL wrap_src_lo got %h want 01", r);
    end
    reg_rd(ra(0, 3), r);
    checks++;
    if (r !== 8'h7C) begin
      errors++;
      $display("FAIL wrap_dst_hi got %h want 7c", r);
    end
    reg_rd(ra(0, 6), r);
    checks++;
    if (r !== 8'h04) begin
      errors++;
      $display("FAIL wrap_ctrl got %h want 04", r);
    end
  endtask

  task automatic test_len_zero();
    logic [7:0] r;
    do_reset();
    clear_mon();
    reg_wr(ra(1, 6), 8'h01);
    checks++;
    if (done !== 2'b10) begin
      errors++;
      $display("FAIL len0_done got %b want 10", done);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (rq_seen !== 1'b0) begin
      errors++;
      $display("FAIL len0_busrq got %b want 0", rq_seen);
    end
    reg_rd(ra(1, 7), r);
    checks++;
    if (r !== 8'h02) begin
      errors++;
      $display("FAIL len0_status got %h want 02", r);
    end
  endtask

  task automatic test_wait_states();
    int n = 0;
    int g = 0;
    do_reset();
    clear_mon();
    setup(0, 16'h1300, 16'h4000, 16'd2);
    reg_wr(ra(0, 6), 8'h01);
    while (m_obus.rdn !== 1'b0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    g = 0;
    while (m_obus.rdn === 1'b0 && g < 200) begin
      if (cen) begin
        n++;
        mw = (n >= 2 && n <= 4) ? 1'b0 : 1'b1;
      end
      @(negedge clk);
      g++;
    end
    mw = 1'b1;
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL ws_rd_len got %0d want 5", n);
    end
    wait_done(2'b01, "ws_done");
    checks++;
    if (waddr.size() != 2) begin
      errors++;
      $display("FAIL ws_count got %0d want 2", waddr.size());
    end else begin
      checks++;
      if (waddr[0] !== 16'h4000 || wdata[0] !== mem(16'h1300)
          || wdata[1] !== mem(16'h1301)) begin
        errors++;
        $display("FAIL ws_data got %h:%h,%h want 4000:%h,%h",
                 waddr[0], wdata[0], wdata[1],
                 mem(16'h1300), mem(16'h1301));
      end
    end
  endtask

  task automatic test_rdy_pause();
    logic [7:0] r;
    int g = 0;
    do_reset();
    clear_mon();
    setup(0, 16'h1400, 16'h5000, 16'd4);
    reg_wr(ra(0, 6), 8'h01);
    while (waddr.size() < 1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    rdy = 1'b0;
    repeat (200) @(negedge clk);
    checks++;
    if (waddr.size() != 1 || busrq !== 1'b0) begin
      errors++;
      $display("FAIL rdy_pause writes=%0d busrq=%b want 1 0",
               waddr.size(), busrq);
    end
    reg_rd(ra(0, 7), r);
    checks++;
    if (r !== 8'h01) begin
      errors++;
      $display("FAIL rdy_status got %h want 01", r);
    end
    rdy = 1'b1;
    wait_done(2'b01, "rdy_done");
    checks++;
    if (waddr.size() != 4) begin
      errors++;
      $display("FAIL rdy_count got %0d want 4", waddr.size());
    end else begin
      checks++;
      if (waddr[3] !== 16'h5003 || wdata[3] !== mem(16'h1403)) begin
        errors++;
        $display("FAIL rdy_last got %h:%h want 5003:%h",
                 waddr[3], wdata[3], mem(16'h1403));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    int g = 0;
    do_reset();
    clear_mon();
    setup(0, 16'h1500, 16'h5800, 16'd4);
    reg_wr(ra(0, 6), 8'h01);
    while (m_obus.wrn !== 1'b0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (m_obus.wrn !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_seen got %b want 0", m_obus.wrn);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_obus.wrn !== 1'b1 || m_obus.mreqn !== 1'b1
        || busrq !== 1'b0 || done !== 2'b00) begin
      errors++;
      $display("FAIL rst_async wrn=%b mreqn=%b busrq=%b done=%b want 1 1 0 00",
               m_obus.wrn, m_obus.mreqn, busrq, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reg_rd(ra(0, 7), r);
    checks++;
    if (r !== 8'h00) begin
      errors++;
      $display("FAIL rst_status got %h want 00", r);
    end
    reg_rd(ra(0, 4), r);
    checks++;
    if (r !== 8'h00) begin
      errors++;
      $display("FAIL rst_len got %h want 00", r);
    end
  endtask

  initial begin
    s_ibus = '{addr: 16'h0, dmaster: 8'h0, mreqn: 1'b1,
               iorqn: 1'b1, rdn: 1'b1, wrn: 1'b1};
    test_reset();
    test_block();
    test_round_robin();
    test_wrap_fix();
    test_len_zero();
    test_wait_states();
    test_rdy_pause();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_multidma.md
# z80_multidma

Parametrised multi-channel memory-to-memory DMA controller for the Z80 system bus, the successor to the single-channel fake DMA. It exposes a per-channel register window as a bus slave, takes the bus from the CPU with a BUSRQ/BUSACK handshake, and moves byte blocks as a bus master in bursts, with round-robin arbitration between channels. Bus cycles are paced by the CPU clock-enable, so DMA cycles have the same shape as CPU cycles on the shared bus.

## Interface
- CHANNELS, 2: number of channels, 1..8.
- LEN_W, 16: width of each channel's byte-count register, 1..16.
- BURST, 0: bytes per bus tenure before BUSRQ is released; 0 means the whole block.
- clk  in  1  system clock (masterclk domain).
- rst_n  in  1  reset: asynchronous assert, active-low.
- cen  in  1  one-clk pulse on each CPU clock rise; the FSM advances only on cen.
- ena  in  1  slave select for the register window, from the address decoder.
- s_ibus  in  Z80MasterBus  shared master bus (slave side).
- s_obus  out  Z80SlaveBus  register readback; mwait fixed at 1.
- m_obus  out  Z80MasterBus  DMA master bus.
- m_ibus  in  Z80SlaveBus  shared slave bus (read data, mwait).
- busrq  out  1  bus request, active-high.
- busack  in  1  bus granted, active-high.
- rdy  in  1  global DMA permit (bitmapped IO latch).
- done  out  CHANNELS  per-channel done flag, level.

## Operation
- Register map: channel c at s_ibus.addr[k+2:3] = c, where k = clog2(CHANNELS), so each channel occupies 8 bytes. Offsets, register index addr[2:0]:
  - +0/+1 SRC lo/hi.
  - +2/+3 DST lo/hi.
  - +4/+5 LEN lo/hi; bits above LEN_W read 0.
  - +6 CTRL: bit0 START (write-only, reads 0), bit1 SRC_FIX, bit2 DST_FIX.
  - +7 STATUS: bit0 BUSY, bit1 DONE; read-only.
- Register writes: taken when ena=1, wrn=0 and mreqn=0, once per bus cycle on the falling edge of wrn. While the channel is BUSY, writes to SRC, DST, LEN and CTRL are ignored.
- Register reads: s_obus.dslave is registered; addressed data is valid the clk after ena and rdn=0.
- START=1 with LEN≠0: sets BUSY and PENDING, clears DONE.
- START=1 with LEN=0: sets DONE only; no bus activity.
- FSM states: IDLE, REQ, RD, WR, NEXT, REL.
  - IDLE: if rdy=1 and any channel is PENDING, select a channel round-robin starting after the last-served channel, assert busrq, go to REQ.
  - REQ: on cen with busack=1, go to RD.
  - RD: drive addr=SRC, mreqn=0, rdn=0. On the 2nd cen in RD with m_ibus.mwait=1, latch dslave and go to WR. mwait=0 extends the state one cen at a time.
  - WR: drive addr=DST, dmaster=latched byte, mreqn=0. wrn=0 from the 1st cen; wrn goes high and the FSM moves to NEXT on the 2nd cen with mwait=1.
  - NEXT: LEN−1. SRC+1 unless SRC_FIX; DST+1 unless DST_FIX. Addresses wrap FFFFh→0000h.
    - If LEN reaches 0: BUSY=0, PENDING=0, DONE=1, go to REL.
    - Else if the BURST count is reached or rdy=0: go to REL; the channel stays PENDING.
    - Else go to RD.
  - REL: deassert busrq and go to IDLE. The FSM always returns to IDLE before serving any channel, including the same one.
- DONE clears only on a START write.
- busack dropping while in RD/WR: abort the current byte. Its registers are unchanged, strobes go inactive, and the FSM goes to REQ with busrq held. The byte is retried when the grant returns.
- When not in RD/WR, m_obus drives rdn=wrn=mreqn=iorqn=1 and addr=0.

## Timing
- Reset values: busrq=0, done=0, m_obus strobes=1, m_obus addr=0, m_obus dmaster=0, s_obus.dslave=0, s_obus.mwait=1. All channel registers reset to 0. Round-robin pointer resets to the last channel, so channel 0 is served first.
- Bus request: busrq rises on the clk after the START write when rdy=1. The first RD begins on the first cen with busack=1.
- Throughput: 4 cen per byte (2 RD + 2 WR) plus 1 cen for NEXT, with no wait states.
- Bus release: busrq falls on the cen after the NEXT that ends a burst or block.
- Simultaneous events:
  - START and a grant in the same clk: the new channel is eligible from the next IDLE.
  - Reset mid-transfer: everything returns immediately to reset values; no partial write is completed.

## Test plan
- Ch0 SRC=1000h, DST=6000h, LEN=4, START; busack follows busrq 2 cen later -> 4 bytes copied; DONE0=1; busrq low; SRC=1004h, DST=6004h.
- Ch0 LEN=3, ch1 LEN=3, BURST=1, both started together -> bus tenures serve ch0, ch1, ch0, ch1, ch0, ch1; each tenure carries exactly one byte.
- DST_FIX=1, DST=7C00h, SRC=FFFEh, LEN=3 -> writes to 7C00h only; reads FFFEh, FFFFh, 0000h.
- LEN=0 START -> DONE=1 the next clk; busrq never asserts.
- m_ibus.mwait=0 for 3 cen during RD -> RD extends 3 cen; the correct byte is written. rdy dropped mid-block -> current byte completes, bus released, channel resumes when rdy=1.
- rst_n low during WR -> wrn=1 and busrq=0 asynchronously; STATUS reads 00h after reset.
